// File: rtl/quant_arbiter.sv
// quant_arbiter: round-robin packet arbiter that feeds a single quantizer.
// A requester, once granted, keeps the quantizer until its last beat is taken.
// Its shift amount is captured when the grant is issued. Beats pass through one
// registered output slot, so they reach the quantizer one cycle after they are
// accepted.
module quant_arbiter #(
  parameter int BW_I     = 32,
  parameter int N_REQ    = 2,
  parameter int SHIFT_BW = $clog2(BW_I)
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [N_REQ*BW_I-1:0]     req_data_i,
  input  logic [N_REQ-1:0]          req_valid_i,
  input  logic [N_REQ-1:0]          req_last_i,
  output logic [N_REQ-1:0]          req_ready_o,
  input  logic [N_REQ*SHIFT_BW-1:0] req_shift_i,
  output logic [BW_I-1:0]           q_data_o,
  output logic                      q_valid_o,
  output logic                      q_last_o,
  input  logic                      q_ready_i,
  output logic [SHIFT_BW-1:0]       q_shift_o,
  output logic [N_REQ-1:0]          grant_o,
  output logic                      busy_o
);

  localparam int PTR_W = $clog2(N_REQ);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_LOCK = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [PTR_W-1:0]      r_rr_ptr;
  logic [N_REQ-1:0]      r_grant;
  logic [SHIFT_BW-1:0]   r_q_shift;
  logic [BW_I-1:0]       r_q_data;
  logic                  r_q_last;
  logic                  r_q_valid;

  logic [2*N_REQ-1:0]    w_vld_dbl;
  logic [N_REQ-1:0]      w_vld_rot;
  logic [N_REQ-1:0]      w_pick_rot;
  logic [2*N_REQ-1:0]    w_pick_dbl;
  logic [N_REQ-1:0]      w_pick;
  logic [SHIFT_BW-1:0]   w_pick_shift;
  logic                  w_any_req;

  logic [N_REQ-1:0]      w_ready;
  logic                  w_g_valid;
  logic                  w_g_last;
  logic [BW_I-1:0]       w_g_data;
  logic [PTR_W-1:0]      w_nxt_ptr;
  logic                  w_accept;
  logic                  w_accept_last;

  // Round-robin pick: rotate the valid vector so rr_ptr sits at bit 0, take
  // the lowest set bit, then rotate that one-hot back to requester order.
  always_comb begin
    logic found;
    // NOTE: every signal driven here gets a default first; a missed path
    // would otherwise infer a latch.
    found      = 1'b0;
    w_pick_rot = '0;
    w_vld_dbl  = {req_valid_i, req_valid_i} >> r_rr_ptr;
    w_vld_rot  = w_vld_dbl[N_REQ-1:0];
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && w_vld_rot[k]) begin
        w_pick_rot[k] = 1'b1;
        found         = 1'b1;
      end
    end
    w_pick_dbl = {w_pick_rot, w_pick_rot} << r_rr_ptr;
    w_pick     = w_pick_dbl[2*N_REQ-1:N_REQ];
  end

  assign w_any_req = |req_valid_i;

  // Select the shift of the requester about to be granted.
  always_comb begin
    w_pick_shift = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_pick[k]) begin
        w_pick_shift = req_shift_i[k*SHIFT_BW +: SHIFT_BW];
      end
    end
  end

  // Steer the granted requester's stream and compute its successor index.
  always_comb begin
    w_g_valid = 1'b0;
    w_g_last  = 1'b0;
    w_g_data  = '0;
    w_nxt_ptr = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (r_grant[k]) begin
        w_g_valid = req_valid_i[k];
        w_g_last  = req_last_i[k];
        w_g_data  = req_data_i[k*BW_I +: BW_I];
        w_nxt_ptr = (k == N_REQ - 1) ? '0 : PTR_W'(k + 1);
      end
    end
  end

  // Ready only toward the locked requester, and only when the slot can take a
  // beat this edge (empty, or being drained by the quantizer).
  always_comb begin
    w_ready = '0;
    if (r_state == S_LOCK && (!r_q_valid || q_ready_i)) begin
      w_ready = r_grant;
    end
  end

  assign w_accept      = (r_state == S_LOCK) && w_g_valid && (!r_q_valid || q_ready_i);
  assign w_accept_last = w_accept && w_g_last;

  // Next-state logic: grant on any request, release on the last accepted beat.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req)     w_state_nxt = S_LOCK;
      S_LOCK:  if (w_accept_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      r_state <= w_state_nxt;
    end
  end

  // Grant, round-robin pointer and captured shift. The shift only moves when a
  // new grant is issued; changes during a packet are ignored on purpose.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_grant   <= '0;
      r_rr_ptr  <= '0;
      r_q_shift <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_any_req) begin
        r_grant   <= w_pick;
        r_q_shift <= w_pick_shift;
      end
    end else if (w_accept_last) begin
      r_grant  <= '0;
      r_rr_ptr <= w_nxt_ptr;
    end
  end

  // Single-entry output slot: load on accept, hold while stalled, empty when
  // drained with nothing behind it.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      // NOTE: the slot data is reset as well, so a packet cut by reset leaves
      // no stale beat visible on q_data_o.
      r_q_data  <= '0;
      r_q_last  <= 1'b0;
      r_q_valid <= 1'b0;
    end else if (w_accept) begin
      r_q_data  <= w_g_data;
      r_q_last  <= w_g_last;
      r_q_valid <= 1'b1;
    end else if (q_ready_i) begin
      r_q_valid <= 1'b0;
    end
  end

  assign req_ready_o = w_ready;
  assign q_data_o    = r_q_data;
  assign q_last_o    = r_q_last;
  assign q_valid_o   = r_q_valid;
  assign q_shift_o   = r_q_shift;
  assign grant_o     = r_grant;
  assign busy_o      = (r_state == S_LOCK);

endmodule

// File: tb/tb_quant_arbiter.sv
// Directed bench for quant_arbiter with two 32-bit requesters.
module tb_quant_arbiter;

  localparam int BW = 32;
  localparam int N  = 2;
  localparam int SB = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N*BW-1:0] req_data = '0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_last = '0;
  logic [N-1:0]    req_ready;
  logic [N*SB-1:0] req_shift = '0;
  logic [BW-1:0]   q_data;
  logic            q_valid;
  logic            q_last;
  logic            q_ready = 1'b0;
  logic [SB-1:0]   q_shift;
  logic [N-1:0]    grant;
  logic            busy;

  int n_checks = 0;
  int n_errors = 0;

  quant_arbiter #(.BW_I(BW), .N_REQ(N), .SHIFT_BW(SB)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .req_data_i  (req_data),
    .req_valid_i (req_valid),
    .req_last_i  (req_last),
    .req_ready_o (req_ready),
    .req_shift_i (req_shift),
    .q_data_o    (q_data),
    .q_valid_o   (q_valid),
    .q_last_o    (q_last),
    .q_ready_i   (q_ready),
    .q_shift_o   (q_shift),
    .grant_o     (grant),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  // Requester-side packet source description.
  logic [BW-1:0] pk_data [N][8];
  logic          pk_last [N][8];
  int            pk_len [N];
  int            ptr [N];
  int            start_e [N];
  logic [SB-1:0] shift_a [N];
  logic [SB-1:0] shift_b0;
  int            shift_chg_e;
  int            gap_lo, gap_hi;
  int            stall_lo, stall_hi;
  int            cyc;

  // Per-cycle observations, taken just after each rising edge.
  logic [N-1:0]  grant_l [64];
  logic [N-1:0]  rdy_l [64];
  logic          busy_l [64];
  logic          qv_l [64];
  logic          ql_l [64];
  logic [BW-1:0] qd_l [64];
  logic [SB-1:0] sh_l [64];

  // Beats handed to the quantizer, in order.
  logic [BW-1:0] out_d [$];
  logic          out_l [$];
  logic [SB-1:0] out_s [$];

  task automatic setup_clear();
    for (int k = 0; k < N; k++) begin
      pk_len[k]  = 0;
      ptr[k]     = 0;
      start_e[k] = 1000;
      shift_a[k] = '0;
    end
    shift_b0    = '0;
    shift_chg_e = 1000;
    gap_lo      = 1000;
    gap_hi      = 0;
    stall_lo    = 1000;
    stall_hi    = 0;
    cyc         = 0;
    out_d.delete();
    out_l.delete();
    out_s.delete();
  endtask

  task automatic set_pkt(input int k, input logic [BW-1:0] base, input int len,
                         input bit all_last);
    for (int i = 0; i < len; i++) begin
      pk_data[k][i] = base + BW'(i);
      pk_last[k][i] = all_last || (i == len - 1);
    end
    pk_len[k] = len;
  endtask

  // Drive requester/quantizer inputs for the upcoming edge cyc+1.
  task automatic drive_inputs();
    int e;
    e = cyc + 1;
    for (int k = 0; k < N; k++) begin
      logic v;
      v = (e >= start_e[k]) && (ptr[k] < pk_len[k]) &&
          !(k == 0 && e >= gap_lo && e <= gap_hi);
      req_valid[k]            = v;
      req_data[k*BW +: BW]    = v ? pk_data[k][ptr[k]] : '0;
      req_last[k]             = v ? pk_last[k][ptr[k]] : 1'b0;
      req_shift[k*SB +: SB]   = (k == 0 && e >= shift_chg_e) ? shift_b0 : shift_a[k];
    end
    q_ready = !(e >= stall_lo && e <= stall_hi);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_last  = '0;
    q_ready   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    drive_inputs();
    #1;
  endtask

  task automatic run_cycle();
    logic [N-1:0]  acc;
    logic          oxf;
    logic [BW-1:0] od;
    logic          ol;
    logic [SB-1:0] os;
    acc = req_valid & req_ready;
    oxf = q_valid && q_ready;
    od  = q_data;
    ol  = q_last;
    os  = q_shift;
    @(posedge clk);
    #1;
    cyc++;
    if (oxf) begin
      out_d.push_back(od);
      out_l.push_back(ol);
      out_s.push_back(os);
    end
    for (int k = 0; k < N; k++) if (acc[k]) ptr[k]++;
    if (cyc < 64) begin
      grant_l[cyc] = grant;
      busy_l[cyc]  = busy;
      qv_l[cyc]    = q_valid;
      ql_l[cyc]    = q_last;
      qd_l[cyc]    = q_data;
      sh_l[cyc]    = q_shift;
    end
    drive_inputs();
    #1;
    if (cyc < 64) rdy_l[cyc] = req_ready;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 2'b11;
    req_last  = 2'b11;
    req_data  = {32'hDEAD_BEEF, 32'h1234_5678};
    req_shift = {5'd9, 5'd4};
    q_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    if ({q_valid, q_last, busy} !== 3'b000) begin
      $display("FAIL reset_flags got %b expected 000", {q_valid, q_last, busy});
      n_errors++;
    end
    n_checks++;
    if (grant !== 2'b00 || req_ready !== 2'b00) begin
      $display("FAIL reset_grant_ready got %b/%b expected 00/00", grant, req_ready);
      n_errors++;
    end
    n_checks++;
    if (q_data !== '0 || q_shift !== '0) begin
      $display("FAIL reset_data_shift got %h/%0d expected 0/0", q_data, q_shift);
      n_errors++;
    end
    n_checks++;
  endtask

  // Two requesters from reset, 3-beat packets, shifts 4 and 9.
  task automatic test_two_packets();
    logic [BW-1:0] exp_d [6] = '{32'hA0, 32'hA1, 32'hA2, 32'hB0, 32'hB1, 32'hB2};
    logic [SB-1:0] exp_s [6] = '{5'd4, 5'd4, 5'd4, 5'd9, 5'd9, 5'd9};
    logic          exp_l [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    setup_clear();
    set_pkt(0, 32'hA0, 3, 1'b0);
    set_pkt(1, 32'hB0, 3, 1'b0);
    shift_a[0] = 5'd4;
    shift_a[1] = 5'd9;
    start_e[0] = 1;
    start_e[1] = 1;
    do_reset();
    repeat (10) run_cycle();
    if (grant_l[1] !== 2'b01 || sh_l[1] !== 5'd4 || qv_l[1] !== 1'b0) begin
      $display("FAIL two_first_grant got %b/%0d/%b expected 01/4/0", grant_l[1], sh_l[1], qv_l[1]);
      n_errors++;
    end
    n_checks++;
    if (qv_l[2] !== 1'b1 || qd_l[2] !== 32'hA0) begin
      $display("FAIL two_latency got %b/%h expected 1/a0", qv_l[2], qd_l[2]);
      n_errors++;
    end
    n_checks++;
    if (busy_l[4] !== 1'b0 || grant_l[4] !== 2'b00 || rdy_l[4] !== 2'b00 || ql_l[4] !== 1'b1) begin
      $display("FAIL two_idle_gap got busy %b grant %b rdy %b last %b expected 0 00 00 1",
               busy_l[4], grant_l[4], rdy_l[4], ql_l[4]);
      n_errors++;
    end
    n_checks++;
    if (grant_l[5] !== 2'b10 || sh_l[5] !== 5'd9 || qv_l[5] !== 1'b0) begin
      $display("FAIL two_second_grant got %b/%0d/%b expected 10/9/0", grant_l[5], sh_l[5], qv_l[5]);
      n_errors++;
    end
    n_checks++;
    if (out_d.size() !== 6) begin
      $display("FAIL two_count got %0d expected 6", out_d.size());
      n_errors++;
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (out_d[i] !== exp_d[i] || out_s[i] !== exp_s[i] || out_l[i] !== exp_l[i]) begin
          $display("FAIL two_beat%0d got %h/%0d/%b expected %h/%0d/%b",
                   i, out_d[i], out_s[i], out_l[i], exp_d[i], exp_s[i], exp_l[i]);
          n_errors++;
        end
        n_checks++;
      end
    end
    n_checks++;
  endtask

  // Requester 1 alone, 4 beats, quantizer stalls edges 3..5.
  task automatic test_backpressure();
    setup_clear();
    set_pkt(1, 32'hC0, 4, 1'b0);
    shift_a[1] = 5'd3;
    start_e[1] = 1;
    stall_lo   = 3;
    stall_hi   = 5;
    do_reset();
    repeat (10) run_cycle();
    for (int c = 3; c <= 5; c++) begin
      if (qv_l[c] !== 1'b1 || qd_l[c] !== 32'hC0) begin
        $display("FAIL bp_hold_c%0d got %b/%h expected 1/c0", c, qv_l[c], qd_l[c]);
        n_errors++;
      end
      n_checks++;
    end
    if (rdy_l[2] !== 2'b00 || rdy_l[3] !== 2'b00 || rdy_l[4] !== 2'b00) begin
      $display("FAIL bp_ready_low got %b %b %b expected 00 00 00", rdy_l[2], rdy_l[3], rdy_l[4]);
      n_errors++;
    end
    n_checks++;
    if (rdy_l[5] !== 2'b10) begin
      $display("FAIL bp_ready_back got %b expected 10", rdy_l[5]);
      n_errors++;
    end
    n_checks++;
    if (out_d.size() !== 4) begin
      $display("FAIL bp_count got %0d expected 4", out_d.size());
      n_errors++;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (out_d[i] !== 32'hC0 + BW'(i) || out_l[i] !== (i == 3)) begin
          $display("FAIL bp_beat%0d got %h/%b expected %h/%b", i, out_d[i], out_l[i],
                   32'hC0 + BW'(i), (i == 3));
          n_errors++;
        end
        n_checks++;
      end
    end
    n_checks++;
  endtask

  // Locked req0 with a valid gap and a shift change; req1 waits.
  task automatic test_lock_hold();
    setup_clear();
    set_pkt(0, 32'hD0, 4, 1'b0);
    set_pkt(1, 32'h50, 2, 1'b0);
    shift_a[0]  = 5'd4;
    shift_a[1]  = 5'd6;
    shift_b0    = 5'd7;
    shift_chg_e = 3;
    start_e[0]  = 1;
    start_e[1]  = 3;
    gap_lo      = 3;
    gap_hi      = 3;
    do_reset();
    repeat (12) run_cycle();
    if (grant_l[3] !== 2'b01 || busy_l[3] !== 1'b1) begin
      $display("FAIL lock_gap got %b/%b expected 01/1", grant_l[3], busy_l[3]);
      n_errors++;
    end
    n_checks++;
    if (grant_l[4] !== 2'b01 || sh_l[4] !== 5'd4) begin
      $display("FAIL lock_shift got %b/%0d expected 01/4", grant_l[4], sh_l[4]);
      n_errors++;
    end
    n_checks++;
    if (grant_l[6] !== 2'b00 || sh_l[6] !== 5'd4) begin
      $display("FAIL lock_idle_shift got %b/%0d expected 00/4", grant_l[6], sh_l[6]);
      n_errors++;
    end
    n_checks++;
    if (grant_l[7] !== 2'b10 || sh_l[7] !== 5'd6) begin
      $display("FAIL lock_next_grant got %b/%0d expected 10/6", grant_l[7], sh_l[7]);
      n_errors++;
    end
    n_checks++;
    if (out_d.size() !== 6) begin
      $display("FAIL lock_count got %0d expected 6", out_d.size());
      n_errors++;
    end else if (out_d[3] !== 32'hD3 || out_s[3] !== 5'd4 || out_d[4] !== 32'h50 || out_s[4] !== 5'd6) begin
      $display("FAIL lock_order got %h/%0d %h/%0d expected d3/4 50/6",
               out_d[3], out_s[3], out_d[4], out_s[4]);
      n_errors++;
    end
    n_checks++;
  endtask

  // Continuous single-beat packets from both requesters alternate.
  task automatic test_back_to_back();
    logic [BW-1:0] exp_d [8] = '{32'h10, 32'h20, 32'h11, 32'h21, 32'h12, 32'h22, 32'h13, 32'h23};
    setup_clear();
    set_pkt(0, 32'h10, 4, 1'b1);
    set_pkt(1, 32'h20, 4, 1'b1);
    shift_a[0] = 5'd1;
    shift_a[1] = 5'd2;
    start_e[0] = 1;
    start_e[1] = 1;
    do_reset();
    repeat (18) run_cycle();
    if (grant_l[1] !== 2'b01 || grant_l[3] !== 2'b10 || grant_l[5] !== 2'b01 || grant_l[7] !== 2'b10) begin
      $display("FAIL b2b_grants got %b %b %b %b expected 01 10 01 10",
               grant_l[1], grant_l[3], grant_l[5], grant_l[7]);
      n_errors++;
    end
    n_checks++;
    if (qv_l[2] !== 1'b1 || qv_l[3] !== 1'b0 || qv_l[4] !== 1'b1) begin
      $display("FAIL b2b_rate got %b %b %b expected 1 0 1", qv_l[2], qv_l[3], qv_l[4]);
      n_errors++;
    end
    n_checks++;
    if (out_d.size() !== 8) begin
      $display("FAIL b2b_count got %0d expected 8", out_d.size());
      n_errors++;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (out_d[i] !== exp_d[i] || out_l[i] !== 1'b1) begin
          $display("FAIL b2b_beat%0d got %h/%b expected %h/1", i, out_d[i], out_l[i], exp_d[i]);
          n_errors++;
        end
        n_checks++;
      end
    end
    n_checks++;
  endtask

  // Reset in the middle of a 5-beat packet after rr_ptr has moved to 1.
  task automatic test_mid_reset();
    setup_clear();
    set_pkt(0, 32'hE0, 1, 1'b0);
    set_pkt(1, 32'h70, 5, 1'b0);
    shift_a[0] = 5'd2;
    shift_a[1] = 5'd5;
    start_e[0] = 1;
    start_e[1] = 1;
    do_reset();
    repeat (5) run_cycle();
    if (grant_l[3] !== 2'b10 || qv_l[5] !== 1'b1 || qd_l[5] !== 32'h71) begin
      $display("FAIL mrst_pre got %b/%b/%h expected 10/1/71", grant_l[3], qv_l[5], qd_l[5]);
      n_errors++;
    end
    n_checks++;
    rst_n = 1'b0;
    #1;
    if ({q_valid, q_last, busy, grant, req_ready} !== 7'b0 || q_data !== '0 || q_shift !== '0) begin
      $display("FAIL mrst_async got v%b l%b b%b g%b r%b d%h s%0d expected all zero",
               q_valid, q_last, busy, grant, req_ready, q_data, q_shift);
      n_errors++;
    end
    n_checks++;
    @(posedge clk);
    @(negedge clk);
    setup_clear();
    set_pkt(0, 32'h80, 1, 1'b0);
    set_pkt(1, 32'h90, 1, 1'b0);
    shift_a[0] = 5'd3;
    shift_a[1] = 5'd7;
    start_e[0] = 1;
    start_e[1] = 1;
    rst_n = 1'b1;
    drive_inputs();
    #1;
    repeat (6) run_cycle();
    if (grant_l[1] !== 2'b01 || sh_l[1] !== 5'd3) begin
      $display("FAIL mrst_rearb got %b/%0d expected 01/3", grant_l[1], sh_l[1]);
      n_errors++;
    end
    n_checks++;
    if (out_d.size() !== 2) begin
      $display("FAIL mrst_count got %0d expected 2", out_d.size());
      n_errors++;
    end else if (out_d[0] !== 32'h80 || out_d[1] !== 32'h90) begin
      $display("FAIL mrst_order got %h %h expected 80 90", out_d[0], out_d[1]);
      n_errors++;
    end
    n_checks++;
  endtask

  initial begin
    test_reset();
    test_two_packets();
    test_backpressure();
    test_lock_hold();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
